mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Memory-side responder for the cache-to-controller request interface: accepts word read/write requests from the data cache and word reads from the instruction cache, arbitrates between them, and drives the single-ported RAM. Sits between both caches and the RAM model, supplying the `dwait`/`iwait` handshake and load data the caches consume during fills, writebacks and halt flushes.

## Interface
- `STARVE_LIMIT`, 4: consecutive dcache grants allowed while icache is pending (guard build only); 1..7.
- `ERR_WORD`, 32'hBAD1BAD1: load data returned on a RAM error completion.
- `CLK`  in  1  clock, rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `dREN`  in  1  dcache read request.
- `dWEN`  in  1  dcache write request; wins over `dREN` if both high.
- `daddr`  in  32  dcache word address.
- `dstore`  in  32  dcache write data.
- `iREN`  in  1  icache read request.
- `iaddr`  in  32  icache word address.
- `dwait`  out  1  low only in the dcache completion cycle.
- `dload`  out  32  read data, valid when `dwait`=0.
- `iwait`  out  1  low only in the icache completion cycle.
- `iload`  out  32  read data, valid when `iwait`=0.
- `ramREN`, `ramWEN`  out  1  RAM strobes.
- `ramaddr`, `ramstore`  out  32  RAM address / write data.
- `ramload`  in  32  RAM read data.
- `ramstate`  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- `ram_err`  out  1  sticky: an ERROR completion has occurred.

## Operation
- States: IDLE, DGRANT, IGRANT. Grant is registered; the RAM is driven only from a GRANT state.
- IDLE: dcache request (`dREN|dWEN`) -> DGRANT; else `iREN` -> IGRANT; else stay. All RAM strobes 0.
- DGRANT: `ramaddr`=`daddr`; `ramWEN`=`dWEN`, `ramREN`=`dREN & !dWEN`, `ramstore`=`dstore`. IGRANT: `ramaddr`=`iaddr`, `ramREN`=1.
- Completion: in a GRANT state when `ramstate`==ACCESS, the granted wait goes low combinationally and its load equals `ramload`; next state IDLE.
- ERROR in a GRANT state: completes the same way, but the load is `ERR_WORD`; `ram_err` is set the next edge and held until reset.
- FREE/BUSY: hold grant, keep strobes and wait high.
- Request withdrawn while granted (granted enables both 0): strobes drop the same cycle, no completion, IDLE next edge.
- Address/data changes while granted are passed through the same cycle; the caches keep them stable.
- Non-granted side always sees wait=1 and load=0. Loads are 0 outside completion cycles.
- Minimum transaction: 2 cycles (IDLE grant cycle + ACCESS cycle). Back-to-back requests pass through IDLE for one cycle between them.

## Timing
- Reset (async): state IDLE, `dwait`=`iwait`=1, `dload`=`iload`=0, RAM strobes 0, `ramaddr`=`ramstore`=0, `ram_err`=0, starvation counter 0.
- Reset mid-transaction: abort immediately; no completion is reported.
- `dwait`, `iwait`, loads and RAM outputs are combinational from the state, requests and `ramstate`. No combinational path from `ramload` to the strobes.
- Simultaneous d/i requests in IDLE: dcache wins, unless the guard forces icache (see Configuration).

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - A saturating counter increments on each dcache completion while `iREN` is high.
  - The counter clears on each icache completion.
  - When count ≥ `STARVE_LIMIT` and both sides request in IDLE, icache is granted.
- Undefined: strict dcache priority; no counter is present.

## Test plan
- dREN, `daddr`=0x100, `ramstate` BUSY 3 cycles then ACCESS with `ramload`=0xCAFEF00D -> `ramREN`=1 from cycle 1; `dwait`=0 and `dload`=0xCAFEF00D in cycle 4 only; IDLE in cycle 5.
- dWEN, `daddr`=0x3100, `dstore`=0x12 -> `ramWEN`=1, `ramaddr`=0x3100, `ramstore`=0x12; `iwait` stays 1 throughout.
- iREN and dREN asserted together, RAM always ACCESS -> dcache completes first; icache completes 2 cycles later.
- Guard build, `STARVE_LIMIT`=4: dREN and iREN held continuously -> exactly 4 dcache completions, then 1 icache completion. Non-guard build: icache never completes.
- ERROR response on an icache read -> `iwait`=0 with `iload`=0xBAD1BAD1; `ram_err`=1 from the next cycle onward.
- Assert nRST while in DGRANT -> all outputs return to reset values immediately; no `dwait`=0 pulse occurs.

Source files
------------

// File: rtl/mem_arbiter.sv
// Memory-side arbiter between the dcache and icache request ports and a single-ported RAM.
// Optional icache starvation guard is enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter logic [31:0] ERR_WORD     = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        iwait,
    output logic [31:0] iload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        ram_err
);

    localparam int unsigned CNT_W      = 3;
    localparam logic [1:0]  RAM_ACCESS = 2'd2;
    localparam logic [1:0]  RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } state_t;

    state_t             state;
    logic               d_req_c;
    logic               ram_done_c;
    logic               d_done_c;
    logic               i_done_c;
    logic               starve_hit_c;
    logic [31:0]        ram_word_c;
    logic [CNT_W-1:0]   starve_cnt;

    assign d_req_c    = dREN | dWEN;
    assign ram_done_c = (ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR);
    assign ram_word_c = (ramstate == RAM_ERROR) ? ERR_WORD : ramload;
    assign d_done_c   = (state == DGRANT) && d_req_c && ram_done_c;
    assign i_done_c   = (state == IGRANT) && iREN && ram_done_c;

`ifdef MEM_ARB_STARVE_GUARD_EN
    // Saturating count of dcache wins taken while the icache was waiting.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            starve_cnt <= '0;
        end else if (i_done_c) begin
            starve_cnt <= '0;
        end else if (d_done_c && iREN && (starve_cnt != '1)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end
`else
    // No counter: tied to zero so the threshold compare below folds to 0.
    assign starve_cnt = '0;
`endif

    assign starve_hit_c = (starve_cnt >= CNT_W'(STARVE_LIMIT));

    // Grant FSM and sticky error flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= IDLE;
            ram_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (iREN && (!d_req_c || starve_hit_c)) begin
                        state <= IGRANT;
                    end else if (d_req_c) begin
                        state <= DGRANT;
                    end
                end
                DGRANT: begin
                    if (!d_req_c || d_done_c) begin
                        state <= IDLE;
                    end
                end
                IGRANT: begin
                    if (!iREN || i_done_c) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if ((d_done_c || i_done_c) && (ramstate == RAM_ERROR)) begin
                ram_err <= 1'b1;
            end
        end
    end

    // RAM drive and cache handshake, combinational from the grant.
    always_comb begin
        dwait    = 1'b1;
        iwait    = 1'b1;
        dload    = '0;
        iload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (d_done_c) begin
                    dwait = 1'b0;
                    dload = ram_word_c;
                end
            end
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (i_done_c) begin
                    iwait = 1'b0;
                    iload = ram_word_c;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard testbench for mem_arbiter; expected completions are queued as
// stimulus is driven and checked by a monitor when a wait line drops.
module tb_mem_arbiter;

    localparam logic [1:0] R_FREE   = 2'd0;
    localparam logic [1:0] R_BUSY   = 2'd1;
    localparam logic [1:0] R_ACCESS = 2'd2;
    localparam logic [1:0] R_ERROR  = 2'd3;

    typedef struct packed {
        logic        side;   // 0 = dcache, 1 = icache
        logic [31:0] data;
    } exp_t;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        dREN, dWEN, iREN;
    logic [31:0] daddr, dstore, iaddr, ramload;
    logic [1:0]  ramstate;
    logic        dwait, iwait, ramREN, ramWEN, ram_err;
    logic [31:0] dload, iload, ramaddr, ramstore;

    exp_t sb_q[$];
    exp_t mon_e;
    int   vectors    = 0;
    int   miscompares = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(
        .STARVE_LIMIT(4),
        .ERR_WORD    (32'hBAD1BAD1)
    ) dut (
        .CLK     (CLK),
        .nRST    (nRST),
        .dREN    (dREN),
        .dWEN    (dWEN),
        .daddr   (daddr),
        .dstore  (dstore),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .dwait   (dwait),
        .dload   (dload),
        .iwait   (iwait),
        .iload   (iload),
        .ramREN  (ramREN),
        .ramWEN  (ramWEN),
        .ramaddr (ramaddr),
        .ramstore(ramstore),
        .ramload (ramload),
        .ramstate(ramstate),
        .ram_err (ram_err)
    );

    // Every completion must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (dwait === 1'b0 || iwait === 1'b0) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected: dwait=%b iwait=%b with no completion expected", dwait, iwait);
            end else begin
                mon_e = sb_q.pop_front();
                if (dwait === 1'b0 && iwait === 1'b0) begin
                    miscompares++;
                    $display("FAIL sb_both: both waits low, expected side %0d only", mon_e.side);
                end else if ((iwait === 1'b0) !== mon_e.side) begin
                    miscompares++;
                    $display("FAIL sb_side: got side %0d want side %0d", (iwait === 1'b0), mon_e.side);
                end else if (((iwait === 1'b0) ? iload : dload) !== mon_e.data) begin
                    miscompares++;
                    $display("FAIL sb_data: got %h want %h", (iwait === 1'b0) ? iload : dload, mon_e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_dut();
        nRST = 1'b0; dREN = 1'b0; dWEN = 1'b0; iREN = 1'b0;
        daddr = '0; dstore = '0; iaddr = '0; ramload = '0; ramstate = R_FREE;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        nRST = 1'b1; dREN = 1'b1; dWEN = 1'b0; iREN = 1'b1;
        daddr = 32'h44; dstore = 32'h55; iaddr = 32'h66; ramload = 32'h77; ramstate = R_ACCESS;
        #2 nRST = 1'b0;
        #1;
        vectors++;
        if ({dwait, iwait, ramREN, ramWEN, ram_err} !== 5'b11000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 11000", {dwait, iwait, ramREN, ramWEN, ram_err});
        end
        vectors++;
        if ({dload, iload, ramaddr, ramstore} !== 128'd0) begin
            miscompares++;
            $display("FAIL reset_data: got %h want 0", {dload, iload, ramaddr, ramstore});
        end
        reset_dut();
    endtask

    task automatic test_read_wait();
        reset_dut();
        dREN = 1'b1; daddr = 32'h100; ramload = 32'hCAFEF00D; ramstate = R_BUSY;
        @(negedge CLK);
        vectors++;
        if ({ramREN, dwait} !== 2'b01) begin
            miscompares++;
            $display("FAIL rd_cycle0: got ramREN,dwait=%b want 01", {ramREN, dwait});
        end
        for (int c = 1; c <= 3; c++) begin
            step();
            @(negedge CLK);
            vectors++;
            if ({ramREN, dwait, ramaddr, dload} !== {2'b11, 32'h100, 32'h0}) begin
                miscompares++;
                $display("FAIL rd_busy%0d: got %b/%h/%h want 11/00000100/0", c, {ramREN, dwait}, ramaddr, dload);
            end
        end
        step();
        ramstate = R_ACCESS;
        sb_q.push_back('{side: 1'b0, data: 32'hCAFEF00D});
        @(negedge CLK);
        vectors++;
        if ({dwait, dload} !== {1'b0, 32'hCAFEF00D}) begin
            miscompares++;
            $display("FAIL rd_done: got %b/%h want 0/cafef00d", dwait, dload);
        end
        step();
        dREN = 1'b0; ramstate = R_FREE;
        @(negedge CLK);
        vectors++;
        if ({ramREN, dwait, dload} !== {2'b01, 32'h0}) begin
            miscompares++;
            $display("FAIL rd_idle: got %b/%h want 01/0", {ramREN, dwait}, dload);
        end
    endtask

    task automatic test_write();
        reset_dut();
        dWEN = 1'b1; dREN = 1'b1; daddr = 32'h3100; dstore = 32'h12;
        ramload = 32'h55AA; ramstate = R_BUSY;
        @(negedge CLK);
        step();
        @(negedge CLK);
        vectors++;
        if ({ramWEN, ramREN, ramaddr, ramstore, iwait} !== {2'b10, 32'h3100, 32'h12, 1'b1}) begin
            miscompares++;
            $display("FAIL wr_drive: got %b %h %h iwait=%b want 10 3100 12 1", {ramWEN, ramREN}, ramaddr, ramstore, iwait);
        end
        step();
        ramstate = R_ACCESS;
        sb_q.push_back('{side: 1'b0, data: 32'h55AA});
        @(negedge CLK);
        vectors++;
        if ({dwait, iwait, iload} !== {2'b01, 32'h0}) begin
            miscompares++;
            $display("FAIL wr_done: got dwait=%b iwait=%b iload=%h want 0 1 0", dwait, iwait, iload);
        end
        step();
        dWEN = 1'b0; dREN = 1'b0; ramstate = R_FREE;
    endtask

    task automatic test_simultaneous();
        reset_dut();
        dREN = 1'b1; iREN = 1'b1; daddr = 32'h200; iaddr = 32'h400;
        ramload = 32'h11112222; ramstate = R_ACCESS;
        sb_q.push_back('{side: 1'b0, data: 32'h11112222});
        sb_q.push_back('{side: 1'b1, data: 32'h11112222});
        @(negedge CLK);
        step();
        @(negedge CLK);
        vectors++;
        if ({dwait, iwait, iload, ramaddr} !== {2'b01, 32'h0, 32'h200}) begin
            miscompares++;
            $display("FAIL sim_dfirst: got %b %h %h want 01 0 200", {dwait, iwait}, iload, ramaddr);
        end
        step();
        dREN = 1'b0;
        @(negedge CLK);
        vectors++;
        if ({dwait, iwait, ramREN} !== 3'b110) begin
            miscompares++;
            $display("FAIL sim_gap: got %b want 110", {dwait, iwait, ramREN});
        end
        step();
        @(negedge CLK);
        vectors++;
        if ({dwait, iwait, ramaddr, dload} !== {2'b10, 32'h400, 32'h0}) begin
            miscompares++;
            $display("FAIL sim_ilater: got %b %h %h want 10 400 0", {dwait, iwait}, ramaddr, dload);
        end
        step();
        iREN = 1'b0; ramstate = R_FREE;
    endtask

    task automatic test_withdraw();
        reset_dut();
        dREN = 1'b1; daddr = 32'h900; ramload = 32'h0F0F0F0F; ramstate = R_BUSY;
        step();
        @(negedge CLK);
        vectors++;
        if (ramREN !== 1'b1) begin
            miscompares++;
            $display("FAIL wd_grant: got ramREN=%b want 1", ramREN);
        end
        step();
        dREN = 1'b0; ramstate = R_ACCESS;
        @(negedge CLK);
        vectors++;
        if ({ramREN, ramWEN, dwait} !== 3'b001) begin
            miscompares++;
            $display("FAIL wd_drop: got %b want 001", {ramREN, ramWEN, dwait});
        end
        step();
        dREN = 1'b1;
        @(negedge CLK);
        vectors++;
        if ({ramREN, dwait} !== 2'b01) begin
            miscompares++;
            $display("FAIL wd_idle: got %b want 01", {ramREN, dwait});
        end
        step();
        sb_q.push_back('{side: 1'b0, data: 32'h0F0F0F0F});
        @(negedge CLK);
        step();
        dREN = 1'b0; ramstate = R_FREE;
    endtask

    task automatic test_starvation();
        int dc = 0;
        int ic = 0;
        int exp_d;
        int exp_i;
        reset_dut();
        dREN = 1'b1; iREN = 1'b1; daddr = 32'h500; iaddr = 32'h600;
        ramload = 32'hA5A50000; ramstate = R_ACCESS;
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_d = 4; exp_i = 1;
        for (int k = 0; k < 4; k++) sb_q.push_back('{side: 1'b0, data: 32'hA5A50000});
        sb_q.push_back('{side: 1'b1, data: 32'hA5A50000});
`else
        exp_d = 5; exp_i = 0;
        for (int k = 0; k < 5; k++) sb_q.push_back('{side: 1'b0, data: 32'hA5A50000});
`endif
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (dwait === 1'b0) dc++;
            if (iwait === 1'b0) ic++;
            step();
        end
        dREN = 1'b0; iREN = 1'b0; ramstate = R_FREE;
        vectors++;
        if (dc !== exp_d || ic !== exp_i) begin
            miscompares++;
            $display("FAIL starve_counts: got d=%0d i=%0d want d=%0d i=%0d", dc, ic, exp_d, exp_i);
        end
    endtask

    task automatic test_error();
        reset_dut();
        iREN = 1'b1; iaddr = 32'h80; ramload = 32'h12345678; ramstate = R_ERROR;
        @(negedge CLK);
        step();
        sb_q.push_back('{side: 1'b1, data: 32'hBAD1BAD1});
        @(negedge CLK);
        vectors++;
        if ({iwait, iload, ram_err} !== {1'b0, 32'hBAD1BAD1, 1'b0}) begin
            miscompares++;
            $display("FAIL err_done: got %b %h err=%b want 0 bad1bad1 0", iwait, iload, ram_err);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            iREN = 1'b0; ramstate = R_FREE;
            @(negedge CLK);
            vectors++;
            if (ram_err !== 1'b1) begin
                miscompares++;
                $display("FAIL err_sticky%0d: got %b want 1", c, ram_err);
            end
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        dREN = 1'b1; daddr = 32'h700; dstore = 32'h0; ramload = 32'hDEADBEEF; ramstate = R_BUSY;
        step();
        #1;
        vectors++;
        if ({ramREN, ramaddr} !== {1'b1, 32'h700}) begin
            miscompares++;
            $display("FAIL rm_grant: got %b %h want 1 700", ramREN, ramaddr);
        end
        nRST = 1'b0;
        #1;
        vectors++;
        if ({dwait, iwait, ramREN, ramWEN, ram_err, dload, iload, ramaddr, ramstore} !== {5'b11000, 128'd0}) begin
            miscompares++;
            $display("FAIL rm_abort: got %b %h want 11000 0", {dwait, iwait, ramREN, ramWEN, ram_err},
                     {dload, iload, ramaddr, ramstore});
        end
        ramstate = R_ACCESS;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            vectors++;
            if ({dwait, ramREN} !== 2'b10) begin
                miscompares++;
                $display("FAIL rm_hold%0d: got %b want 10", c, {dwait, ramREN});
            end
        end
        step();
        dREN = 1'b0; ramstate = R_FREE; nRST = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_read_wait();
        test_write();
        test_simultaneous();
        test_withdraw();
        test_starvation();
        test_error();
        test_reset_mid();
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_leftover: got %0d pending want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
